// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types for the register-file write-port arbiter:
//   DW_DEF / AW_DEF : default data / register-address widths
//   reg_addr_t      : register address at the default width
//   wb_entry_t      : long-latency result FIFO entry {rd, data}
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned AW_DEF = 5;

    typedef logic [AW_DEF-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t           rd;
        logic [DW_DEF-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundles the writeback-side signals of the register-file write-port arbiter.
//   pipe_*    : MEM_WB writeback slot (data, destination, valid)
//   lu_*      : long-latency unit result handshake (valid/ready)
//   rf_*      : registered register-file write port
//   stall_req : registered request for MEM_WB bubbles
// Modports:
//   slave  : the arbiter (consumes pipe/lu, drives rf/stall/lu_ready)
//   master : the surrounding pipeline / environment
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if
    import wb_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
);

    logic [DW-1:0] pipe_data;
    logic [AW-1:0] pipe_rd;
    logic          pipe_valid;

    logic [DW-1:0] lu_data;
    logic [AW-1:0] lu_rd;
    logic          lu_valid;
    logic          lu_ready;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          stall_req;

    modport slave (
        input  pipe_data, pipe_rd, pipe_valid,
        input  lu_data, lu_rd, lu_valid,
        output lu_ready,
        output rf_we, rf_waddr, rf_wdata, stall_req
    );

    modport master (
        output pipe_data, pipe_rd, pipe_valid,
        output lu_data, lu_rd, lu_valid,
        input  lu_ready,
        input  rf_we, rf_waddr, rf_wdata, stall_req
    );

endinterface

// File: rtl/wb_result_fifo.sv
// ---------------------------------------------------------------------------
// wb_result_fifo
// DEPTH-entry synchronous FIFO holding long-latency results.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_entry at the tail (ignored when full)
//   push_entry : entry to write
//   pop        : consume the head (ignored when empty)
//   head       : current head entry (valid when count != 0)
//   count      : number of stored entries (registered)
// Full/empty come from count; pointers wrap naturally since DEPTH is a
// power of two.
// ---------------------------------------------------------------------------
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = wb_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_entry,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push_ok;
    logic            pop_ok;

    always_comb begin
        push_ok  = push && (count_q < CW'(DEPTH));
        pop_ok   = pop  && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and a long-latency unit. Pipeline writes always win; queued
// long-latency results drain into idle slots (pipe_valid=0 or pipe_rd=0).
// A starvation counter raises stall_req after STARVE_MAX blocked cycles.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : wb_port_arbiter_if.slave (pipe_*, lu_*, rf_*, stall_req)
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned WW = $clog2(STARVE_MAX+1);

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t          fifo_head;
    entry_t          lu_entry;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            lu_push;
    logic            lu_ready;
    logic            pipe_grant;

    logic            rf_we_q,     rf_we_d;
    logic [AW-1:0]   rf_waddr_q,  rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q,  rf_wdata_d;
    logic            stall_req_q, stall_req_d;
    logic [WW-1:0]   wait_cnt_q,  wait_cnt_d;

    // lu_ready depends only on the registered FIFO count.
    assign lu_ready   = (fifo_count < CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign pipe_grant = bus.pipe_valid && (bus.pipe_rd != '0);
    assign fifo_pop   = !pipe_grant && !fifo_empty;
    assign lu_push    = bus.lu_valid && lu_ready;
    assign lu_entry   = '{rd: bus.lu_rd, data: bus.lu_data};

    wb_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (lu_push),
        .push_entry (lu_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_grant) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.pipe_rd;
            rf_wdata_d = bus.pipe_data;
        end else if (fifo_pop && (fifo_head.rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = fifo_head.rd;
            rf_wdata_d = fifo_head.data;
        end

        // Counts consecutive cycles the FIFO head was present but not popped.
        if (fifo_empty || fifo_pop) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WW'(STARVE_MAX)) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        stall_req_d = (wait_cnt_d == WW'(STARVE_MAX));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            stall_req_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            stall_req_q <= stall_req_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.lu_ready  = lu_ready;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.stall_req = stall_req_q;

endmodule
